// File: rtl/ibex_rf_pkg.sv
// Shared types and helpers for the register-file write arbiter.
// Optional post-reset scrub is enabled with the IBEX_RF_SCRUB_EN macro.
package ibex_rf_pkg;

  localparam int RF_ADDR_W = 5;

  typedef enum logic {
    ARB_SCRUB = 1'b0,
    ARB_RUN   = 1'b1
  } rf_arb_state_e;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_CORE = 2'd1,
    SEL_AUX  = 2'd2
  } rf_wr_sel_e;

  // RV32E only implements x0..x15, so any address with bit 4 set is illegal.
  function automatic logic rf_addr_illegal(input logic [RF_ADDR_W-1:0] addr, input logic rv32e);
    return rv32e & addr[RF_ADDR_W-1];
  endfunction

endpackage

// File: rtl/ibex_rf_scrub_seq.sv
// Post-reset scrub sequencer: walks x1..x(N-1), one register per cycle.
// Only present when IBEX_RF_SCRUB_EN is defined.
`ifdef IBEX_RF_SCRUB_EN
module ibex_rf_scrub_seq
  import ibex_rf_pkg::*;
#(
  parameter int RV32E = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  output logic                 busy_o,
  output logic [RF_ADDR_W-1:0] addr_o,
  output logic                 last_o
);

  localparam logic [RF_ADDR_W-1:0] LastAddr = (RV32E != 0) ? 5'd15 : 5'd31;

  logic [RF_ADDR_W-1:0] ptr_q;
  logic                 done_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q  <= 5'd1;
      done_q <= 1'b0;
    end else if (!done_q) begin
      if (ptr_q == LastAddr) done_q <= 1'b1;
      else                   ptr_q  <= ptr_q + 5'd1;
    end
  end

  assign busy_o = ~done_q;
  assign addr_o = ptr_q;
  assign last_o = ~done_q & (ptr_q == LastAddr);

endmodule
`endif

// File: rtl/ibex_rf_write_arbiter.sv
// Shares the register-file write port between core writeback and an aux writer.
// Define IBEX_RF_SCRUB_EN to clear x1..x(N-1) after every reset before granting.
module ibex_rf_write_arbiter
  import ibex_rf_pkg::*;
#(
  parameter int                   DataWidth   = 32,
  parameter int                   RV32E       = 0,
  parameter int                   StarveLimit = 4,
  parameter logic [DataWidth-1:0] WordZeroVal = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 core_req_i,
  input  logic [4:0]           core_addr_i,
  input  logic [DataWidth-1:0] core_wdata_i,
  output logic                 core_gnt_o,
  input  logic                 aux_req_i,
  input  logic [4:0]           aux_addr_i,
  input  logic [DataWidth-1:0] aux_wdata_i,
  output logic                 aux_gnt_o,
  output logic [4:0]           waddr_a_o,
  output logic [DataWidth-1:0] wdata_a_o,
  output logic                 we_a_o,
  output logic                 pend_valid_o,
  output logic [4:0]           pend_addr_o,
  output logic [DataWidth-1:0] pend_data_o,
  output logic                 scrub_busy_o,
  output logic                 err_o
);

  localparam int             CntW      = $clog2(StarveLimit + 1);
  localparam logic [CntW-1:0] StarveMax = CntW'(StarveLimit);

  rf_arb_state_e        state_q, state_d;
  rf_wr_sel_e           sel;
  logic                 scrub_busy, scrub_last;
  logic [RF_ADDR_W-1:0] scrub_addr;
  logic [CntW-1:0]      starve_q;
  logic [RF_ADDR_W-1:0] wr_addr;
  logic [DataWidth-1:0] wr_data;
  logic                 wr_illegal;

`ifdef IBEX_RF_SCRUB_EN
  localparam rf_arb_state_e ResetState = ARB_SCRUB;

  ibex_rf_scrub_seq #(
    .RV32E (RV32E)
  ) u_scrub (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .busy_o (scrub_busy),
    .addr_o (scrub_addr),
    .last_o (scrub_last)
  );
`else
  localparam rf_arb_state_e ResetState = ARB_RUN;

  assign scrub_busy = 1'b0;
  assign scrub_addr = '0;
  assign scrub_last = 1'b0;
`endif

  assign scrub_busy_o = scrub_busy;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ResetState;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_SCRUB: if (scrub_last) state_d = ARB_RUN;
      ARB_RUN:   state_d = ARB_RUN;
      default:   state_d = ARB_RUN;
    endcase
  end

  // Core has priority unless aux has been refused StarveLimit cycles in a row.
  always_comb begin
    sel = SEL_NONE;
    if (state_q == ARB_RUN) begin
      if (aux_req_i && (starve_q == StarveMax)) sel = SEL_AUX;
      else if (core_req_i)                      sel = SEL_CORE;
      else if (aux_req_i)                       sel = SEL_AUX;
    end
  end

  assign core_gnt_o = (sel == SEL_CORE);
  assign aux_gnt_o  = (sel == SEL_AUX);

  assign wr_addr    = (sel == SEL_AUX) ? aux_addr_i  : core_addr_i;
  assign wr_data    = (sel == SEL_AUX) ? aux_wdata_i : core_wdata_i;
  assign wr_illegal = rf_addr_illegal(wr_addr, RV32E != 0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_q <= '0;
    end else if (!aux_req_i || aux_gnt_o) begin
      starve_q <= '0;
    end else if (starve_q != StarveMax) begin
      starve_q <= starve_q + 1'b1;
    end
  end

  // Output stage: x0 and illegal targets still consume the slot but never assert we.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_a_o    <= 1'b0;
      waddr_a_o <= '0;
      wdata_a_o <= WordZeroVal;
      err_o     <= 1'b0;
    end else if (state_q == ARB_SCRUB) begin
      we_a_o    <= 1'b1;
      waddr_a_o <= scrub_addr;
      wdata_a_o <= WordZeroVal;
      err_o     <= 1'b0;
    end else if (sel != SEL_NONE) begin
      we_a_o    <= ~wr_illegal & (wr_addr != '0);
      waddr_a_o <= wr_addr;
      wdata_a_o <= wr_data;
      err_o     <= wr_illegal;
    end else begin
      we_a_o <= 1'b0;
      err_o  <= 1'b0;
    end
  end

  assign pend_valid_o = we_a_o;
  assign pend_addr_o  = waddr_a_o;
  assign pend_data_o  = wdata_a_o;

endmodule

// File: tb/tb_ibex_rf_write_arbiter.sv
// Directed, table-driven bench for ibex_rf_write_arbiter (both scrub builds).
module tb_ibex_rf_write_arbiter;

  logic        clk, rst_n;
  logic        core_req, aux_req, core_gnt, aux_gnt, we, pend_valid, busy, err;
  logic [4:0]  core_addr, aux_addr, waddr, pend_addr;
  logic [31:0] core_wdata, aux_wdata, wdata, pend_data;

  logic        e_core_req, e_aux_req, e_core_gnt, e_aux_gnt, e_we, e_pend_valid, e_busy, e_err;
  logic [4:0]  e_core_addr, e_aux_addr, e_waddr, e_pend_addr;
  logic [31:0] e_core_wdata, e_aux_wdata, e_wdata, e_pend_data;

  int passed = 0;
  int total  = 0;

  ibex_rf_write_arbiter #(.DataWidth(32), .RV32E(0), .StarveLimit(4), .WordZeroVal('0)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .core_req_i(core_req), .core_addr_i(core_addr), .core_wdata_i(core_wdata), .core_gnt_o(core_gnt),
    .aux_req_i(aux_req), .aux_addr_i(aux_addr), .aux_wdata_i(aux_wdata), .aux_gnt_o(aux_gnt),
    .waddr_a_o(waddr), .wdata_a_o(wdata), .we_a_o(we),
    .pend_valid_o(pend_valid), .pend_addr_o(pend_addr), .pend_data_o(pend_data),
    .scrub_busy_o(busy), .err_o(err)
  );

  ibex_rf_write_arbiter #(.DataWidth(32), .RV32E(1), .StarveLimit(4), .WordZeroVal('0)) dut_e (
    .clk_i(clk), .rst_ni(rst_n),
    .core_req_i(e_core_req), .core_addr_i(e_core_addr), .core_wdata_i(e_core_wdata), .core_gnt_o(e_core_gnt),
    .aux_req_i(e_aux_req), .aux_addr_i(e_aux_addr), .aux_wdata_i(e_aux_wdata), .aux_gnt_o(e_aux_gnt),
    .waddr_a_o(e_waddr), .wdata_a_o(e_wdata), .we_a_o(e_we),
    .pend_valid_o(e_pend_valid), .pend_addr_o(e_pend_addr), .pend_data_o(e_pend_data),
    .scrub_busy_o(e_busy), .err_o(e_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        creq;
    logic [4:0]  caddr;
    logic [31:0] cdata;
    logic        areq;
    logic [4:0]  aaddr;
    logic [31:0] adata;
    logic        cg;
    logic        ag;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mkv(logic creq, logic [4:0] caddr, logic [31:0] cdata,
                               logic areq, logic [4:0] aaddr, logic [31:0] adata,
                               logic cg, logic ag, logic w, logic [4:0] wa, logic [31:0] wd);
    vec_t v;
    v.creq = creq; v.caddr = caddr; v.cdata = cdata;
    v.areq = areq; v.aaddr = aaddr; v.adata = adata;
    v.cg = cg; v.ag = ag; v.we = w; v.waddr = wa; v.wdata = wd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_reset_vals(input string tag, input logic exp_busy);
    chk({tag, " we"}, {31'd0, we}, 32'd0);
    chk({tag, " waddr"}, {27'd0, waddr}, 32'd0);
    chk({tag, " wdata"}, wdata, 32'd0);
    chk({tag, " pend_valid"}, {31'd0, pend_valid}, 32'd0);
    chk({tag, " err"}, {31'd0, err}, 32'd0);
    chk({tag, " busy"}, {31'd0, busy}, {31'd0, exp_busy});
  endtask

`ifdef IBEX_RF_SCRUB_EN
  // Called at the negedge where reset was released; checks the 31 scrub writes.
  task automatic scrub_run(input bit hold_core);
    for (int k = 1; k <= 31; k++) begin
      @(negedge clk);
      chk($sformatf("scrub%0d we", k), {31'd0, we}, 32'd1);
      chk($sformatf("scrub%0d waddr", k), {27'd0, waddr}, k);
      chk($sformatf("scrub%0d wdata", k), wdata, 32'd0);
      chk($sformatf("scrub%0d busy", k), {31'd0, busy}, (k < 31) ? 32'd1 : 32'd0);
      if (hold_core) chk($sformatf("scrub%0d core_gnt", k), {31'd0, core_gnt}, (k == 31) ? 32'd1 : 32'd0);
    end
    if (hold_core) begin
      @(negedge clk);
      chk("post-scrub core we", {31'd0, we}, 32'd1);
      chk("post-scrub core waddr", {27'd0, waddr}, 32'd9);
      chk("post-scrub core wdata", wdata, 32'h99);
      core_req = 1'b0;
    end
  endtask
`endif

  initial begin
    // Directed vectors: core addr 3 / aux addr 7 when both request.
    vecs[0]  = mkv(1, 5, 32'hDEADBEEF, 0, 0, 0,            1, 0, 1, 5,  32'hDEADBEEF);
    vecs[1]  = mkv(0, 0, 0,            0, 0, 0,            0, 0, 0, 5,  32'hDEADBEEF);
    vecs[2]  = mkv(1, 0, 32'h1234,     0, 0, 0,            1, 0, 0, 0,  32'h1234);
    vecs[3]  = mkv(0, 0, 0,            1, 31, 32'hA5A5A5A5, 0, 1, 1, 31, 32'hA5A5A5A5);
    for (int i = 4; i <= 7; i++) vecs[i] = mkv(1, 3, 32'h3, 1, 7, 32'h7, 1, 0, 1, 3, 32'h3);
    vecs[8]  = mkv(1, 3, 32'h3,        1, 7, 32'h7,        0, 1, 1, 7,  32'h7);
    vecs[9]  = mkv(0, 0, 0,            1, 12, 32'hC,       0, 1, 1, 12, 32'hC);
    vecs[10] = mkv(1, 3, 32'h3,        1, 7, 32'h7,        1, 0, 1, 3,  32'h3);
    vecs[11] = mkv(1, 3, 32'h3,        1, 7, 32'h7,        1, 0, 1, 3,  32'h3);
    vecs[12] = mkv(1, 3, 32'h3,        0, 7, 32'h7,        1, 0, 1, 3,  32'h3);
    for (int i = 13; i <= 16; i++) vecs[i] = mkv(1, 3, 32'h3, 1, 7, 32'h7, 1, 0, 1, 3, 32'h3);
    vecs[17] = mkv(1, 3, 32'h3,        1, 7, 32'h7,        0, 1, 1, 7,  32'h7);

    rst_n = 1'b0;
    core_req = 0; core_addr = 0; core_wdata = 0;
    aux_req = 0; aux_addr = 0; aux_wdata = 0;
    e_core_req = 0; e_core_addr = 0; e_core_wdata = 0;
    e_aux_req = 0; e_aux_addr = 0; e_aux_wdata = 0;
    repeat (2) @(negedge clk);

`ifdef IBEX_RF_SCRUB_EN
    chk_reset_vals("reset", 1'b1);
    core_req = 1'b1; core_addr = 5'd9; core_wdata = 32'h99;
    rst_n = 1'b1;
    scrub_run(1'b1);

    // Reset in the middle of the scrub, then a full restart from x1.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) @(negedge clk);
    chk("midscrub waddr", {27'd0, waddr}, 32'd10);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("midscrub reset", 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    scrub_run(1'b0);
    chk("rv32e scrub done", {31'd0, e_busy}, 32'd0);
`else
    chk_reset_vals("reset", 1'b0);
    core_req = 1'b1; core_addr = 5'd9; core_wdata = 32'h99;
    rst_n = 1'b1;
    #1;
    chk("first cycle core_gnt", {31'd0, core_gnt}, 32'd1);
    chk("first cycle busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("first write we", {31'd0, we}, 32'd1);
    chk("first write waddr", {27'd0, waddr}, 32'd9);
    chk("first write wdata", wdata, 32'h99);
    core_req = 1'b0;
`endif

    for (int i = 0; i < 18; i++) begin
      core_req = vecs[i].creq; core_addr = vecs[i].caddr; core_wdata = vecs[i].cdata;
      aux_req  = vecs[i].areq; aux_addr  = vecs[i].aaddr; aux_wdata  = vecs[i].adata;
      #1;
      chk($sformatf("v%0d core_gnt", i), {31'd0, core_gnt}, {31'd0, vecs[i].cg});
      chk($sformatf("v%0d aux_gnt", i), {31'd0, aux_gnt}, {31'd0, vecs[i].ag});
      @(negedge clk);
      chk($sformatf("v%0d we", i), {31'd0, we}, {31'd0, vecs[i].we});
      chk($sformatf("v%0d waddr", i), {27'd0, waddr}, {27'd0, vecs[i].waddr});
      chk($sformatf("v%0d wdata", i), wdata, vecs[i].wdata);
      chk($sformatf("v%0d pend_valid", i), {31'd0, pend_valid}, {31'd0, vecs[i].we});
      chk($sformatf("v%0d pend_addr", i), {27'd0, pend_addr}, {27'd0, vecs[i].waddr});
      chk($sformatf("v%0d pend_data", i), pend_data, vecs[i].wdata);
      chk($sformatf("v%0d err", i), {31'd0, err}, 32'd0);
    end

    // Continuous contention: four core grants, then one aux grant, repeating.
    core_req = 1'b1; aux_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("starve%0d core_gnt", i), {31'd0, core_gnt}, (i % 5 != 4) ? 32'd1 : 32'd0);
      chk($sformatf("starve%0d aux_gnt", i), {31'd0, aux_gnt}, (i % 5 == 4) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    core_req = 1'b0; aux_req = 1'b0;
    @(negedge clk);

    // RV32E: aux write to x20 is granted but filtered and flagged.
    e_aux_req = 1'b1; e_aux_addr = 5'd20; e_aux_wdata = 32'h5;
    #1 chk("rv32e aux_gnt", {31'd0, e_aux_gnt}, 32'd1);
    @(negedge clk);
    chk("rv32e illegal we", {31'd0, e_we}, 32'd0);
    chk("rv32e illegal err", {31'd0, e_err}, 32'd1);
    e_aux_req = 1'b0;
    e_core_req = 1'b1; e_core_addr = 5'd15; e_core_wdata = 32'hF0;
    #1 chk("rv32e core_gnt", {31'd0, e_core_gnt}, 32'd1);
    @(negedge clk);
    chk("rv32e err pulse end", {31'd0, e_err}, 32'd0);
    chk("rv32e x15 we", {31'd0, e_we}, 32'd1);
    chk("rv32e x15 waddr", {27'd0, e_waddr}, 32'd15);
    e_core_req = 1'b0;
    @(negedge clk);
    chk("rv32e idle we", {31'd0, e_we}, 32'd0);

    // Reset while a write is staged: it is dropped immediately.
    core_req = 1'b1; core_addr = 5'd6; core_wdata = 32'h66;
    @(negedge clk);
    core_req = 1'b0;
    chk("staged we", {31'd0, we}, 32'd1);
    chk("staged waddr", {27'd0, waddr}, 32'd6);
    #2 rst_n = 1'b0;
    #1;
    chk("midwrite reset we", {31'd0, we}, 32'd0);
    chk("midwrite reset waddr", {27'd0, waddr}, 32'd0);
    chk("midwrite reset wdata", wdata, 32'd0);
    chk("midwrite reset pend_valid", {31'd0, pend_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ibex_rf_write_arbiter.md
# ibex_rf_write_arbiter

Sequences and shares the single write port of the integer register file between the core writeback stage and an auxiliary writer (debug module / long-latency unit). Fixed priority to the core with a starvation guard for the auxiliary port, one registered stage to the register file, x0 and illegal-address filtering, and an optional post-reset scrub that clears every writable register. Sits between the writeback stage and the register file write port (`waddr`/`wdata`/`we`).

## Interface
- `DataWidth`, 32, word width.
- `RV32E`, 0, when 1 only x0–x15 exist; address bit 4 is illegal.
- `StarveLimit`, 4, consecutive denied aux-request cycles before aux is forced a grant (≥1).
- `WordZeroVal`, '0, scrub value; also reset value of `wdata_a_o`.

Ports:
- `clk_i`  in  1  clock, rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `core_req_i`  in  1  core write request.
- `core_addr_i`  in  5  core destination register.
- `core_wdata_i`  in  DataWidth  core write data.
- `core_gnt_o`  out  1  core request accepted this cycle.
- `aux_req_i`  in  1  aux write request.
- `aux_addr_i`  in  5  aux destination register.
- `aux_wdata_i`  in  DataWidth  aux write data.
- `aux_gnt_o`  out  1  aux request accepted this cycle.
- `waddr_a_o`  out  5  register file write address.
- `wdata_a_o`  out  DataWidth  register file write data.
- `we_a_o`  out  1  register file write enable.
- `pend_valid_o`, `pend_addr_o` [4:0], `pend_data_o` [DataWidth]  out  write staged in output register (equal to `we_a_o`/`waddr_a_o`/`wdata_a_o`), for read-side forwarding.
- `scrub_busy_o`  out  1  scrub in progress; no grants.
- `err_o`  out  1  one-cycle pulse: accepted write to an illegal address.

## Operation
- Req/gnt handshake: grant is combinational in the same cycle as the request; the requester holds req, addr, and data stable until granted. At most one grant per cycle.
- Priority: core wins by default. `starve_cnt` increments on each cycle `aux_req_i` is high and `aux_gnt_o` is low, and clears on an aux grant or when `aux_req_i` is low. When `starve_cnt == StarveLimit`, aux wins over core for exactly one grant, then the counter clears.
- An accepted write loads the output register; `we_a_o` is high the next cycle for one cycle.
- Write to x0: granted, `we_a_o` stays 0, `err_o` stays 0.
- RV32E with `addr[4] == 1`: granted, `we_a_o` stays 0, `err_o` pulses high the next cycle.
- FSM states `ARB_SCRUB` and `ARB_RUN`. Reset enters `ARB_SCRUB` (macro on) or `ARB_RUN` (macro off). Transition `ARB_SCRUB`→`ARB_RUN` occurs after the last scrub write; `ARB_RUN` is terminal until reset.

## Timing
- Reset values: `we_a_o`=0, `waddr_a_o`=0, `wdata_a_o`=`WordZeroVal`, `pend_valid_o`=0, `err_o`=0, `starve_cnt`=0, scrub pointer=1.
  - `scrub_busy_o`=1 after reset with the macro, 0 without it.
  - Grants are 0 while `scrub_busy_o` is high.
- Latency, grant to `we_a_o`: 1 cycle. Throughput: 1 write per cycle.
- Simultaneous requests with `starve_cnt < StarveLimit`: core granted. With `starve_cnt == StarveLimit`: aux granted.
- Reset asserted mid-scrub or mid-write: outputs return immediately to reset values. A staged write is lost. Scrub restarts at x1.

## Configuration
- `IBEX_RF_SCRUB_EN` defined:
  - After reset, the block writes `WordZeroVal` to x1..x(N-1), one register per cycle, with `we_a_o`=1. N=16 for RV32E, 32 otherwise.
  - `scrub_busy_o` is high from reset through the cycle of the last scrub write (31 or 15 cycles).
  - The FSM then enters `ARB_RUN`.
- Undefined: no scrub logic. The FSM is `ARB_RUN` from reset, `scrub_busy_o` is tied to 0, and grants are available in the first cycle after reset.

## Structure
- Package `ibex_rf_pkg`:
  - `rf_arb_state_e` (`ARB_SCRUB`, `ARB_RUN`).
  - `rf_wr_sel_e` (`SEL_NONE`, `SEL_CORE`, `SEL_AUX`).
  - `RF_ADDR_W` = 5.
- One sub-module: `ibex_rf_scrub_seq`, which holds the scrub address pointer, done flag, and busy output. It is instantiated only under `IBEX_RF_SCRUB_EN`.
- The arbitration logic, starvation counter, and output register stay in the top module.

## Test plan
- Macro on, reset release → `we_a_o` high for 31 consecutive cycles, `waddr_a_o` 1..31, data `WordZeroVal`, `scrub_busy_o` drops after the last write, `core_req_i` held high gets first grant after.
- `core_req_i` with addr 5, data 0xDEADBEEF → `core_gnt_o` same cycle; next cycle `we_a_o`=1, `waddr_a_o`=5, `pend_data_o`=0xDEADBEEF.
- Core and aux both requesting continuously, `StarveLimit`=4 → core granted 4 cycles, aux granted on 5th, pattern repeats every 5 cycles.
- Core write to x0 → granted, `we_a_o` stays 0; RV32E=1, aux write to addr 20 → granted, `we_a_o` 0, `err_o` one-cycle pulse.
- Assert `rst_ni` low at scrub address 10 → outputs return to reset values immediately; after release, scrub restarts at x1 and completes 31 writes.
- Macro off → `scrub_busy_o`=0 from reset; core request in first post-reset cycle granted, written next cycle.
